axis_msg_streamer: RTL and testbench

Parametrised AXI-Stream packet source that replaces the fixed-depth message master in the UART transmit path. An external controller loads a message buffer through a simple write port, then issues a start pulse. The block streams the stored words on an AXI-Stream master interface with full back-to-back handshaking, `m_axis_last` on the final beat, and optional continuous repeat. It feeds the UART TX FIFO.

---
 rtl/axis_msg_streamer_if.sv | 24 ++
 rtl/axis_msg_streamer.sv | 192 +++++++++++++++++++
 tb/tb_axis_msg_streamer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_msg_streamer_if.sv
// AXI-Stream handshake bundle between the message streamer and its downstream sink.
// The master drives data/valid/last; the slave returns ready.
interface axis_msg_streamer_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             last;
   logic             ready;

   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );
endinterface

// File: rtl/axis_msg_streamer.sv
// AXI-Stream packet source: streams a loaded message buffer with last on the final beat,
// optionally looping packets until a stop request lands on a packet boundary.
module axis_msg_streamer #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_en_i,
   input  logic [AW-1:0]        load_addr_i,
   input  logic [WIDTH-1:0]     load_data_i,
   input  logic [AW:0]          msg_len_i,
   input  logic                 repeat_mode_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   axis_msg_streamer_if.master  m_axis,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 load_err_o,
   output logic [15:0]          pkt_cnt_o
);

   localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW:0]      len_q, len_d;
   logic             rep_q, rep_d;
   logic             stop_pend_q, stop_pend_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             done_q, done_d;
   logic             load_err_q, load_err_d;
   logic [15:0]      pkt_cnt_q, pkt_cnt_d;

   logic             wr_en;
   logic             start_ok;
   logic             hs;
   logic             pkt_end;
   logic             wrap;
   logic [AW:0]      eff_len;
   logic [AW-1:0]    idx_nxt;
   logic [WIDTH-1:0] head_word;

   assign wr_en    = load_en_i && (state_q == StIdle);
   assign start_ok = start_i && (state_q == StIdle);
   assign hs       = valid_q && m_axis.ready;
   assign pkt_end  = (state_q == StStream) && hs && last_q;
   // A stop arriving on the final handshake still makes this packet the last one.
   assign wrap     = pkt_end && rep_q && !stop_pend_q && !stop_i;
   assign eff_len  = (msg_len_i > DepthLen) ? DepthLen : msg_len_i;
   assign idx_nxt  = idx_q + AW'(1);
   // Same-edge write to address 0 must be visible in the first beat.
   assign head_word = (wr_en && (load_addr_i == '0)) ? load_data_i : mem_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[load_addr_i] <= load_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok && (eff_len != '0)) begin
               state_d = StStream;
            end
         end
         StStream: begin
            if (pkt_end && !wrap) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      len_d       = len_q;
      rep_d       = rep_q;
      stop_pend_d = stop_pend_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      done_d      = 1'b0;
      load_err_d  = load_err_q;
      pkt_cnt_d   = pkt_cnt_q;

      if (start_ok) begin
         load_err_d = 1'b0;
      end else if (load_en_i && (state_q == StStream)) begin
         load_err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            stop_pend_d = 1'b0;
            if (start_ok) begin
               len_d = eff_len;
               rep_d = repeat_mode_i;
               idx_d = '0;
               if (eff_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  data_d  = head_word;
                  last_d  = (eff_len == (AW+1)'(1));
               end
            end
         end
         StStream: begin
            if (stop_i && rep_q) begin
               stop_pend_d = 1'b1;
            end
            if (hs) begin
               if (last_q) begin
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
                  idx_d     = '0;
                  if (wrap) begin
                     data_d = head_word;
                     last_d = (len_q == (AW+1)'(1));
                  end else begin
                     valid_d     = 1'b0;
                     last_d      = 1'b0;
                     done_d      = 1'b1;
                     stop_pend_d = 1'b0;
                  end
               end else begin
                  idx_d  = idx_nxt;
                  data_d = mem_q[idx_nxt];
                  last_d = ((AW+1)'(idx_q) + (AW+1)'(2)) == len_q;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q       <= '0;
         len_q       <= '0;
         rep_q       <= 1'b0;
         stop_pend_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         load_err_q  <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         idx_q       <= idx_d;
         len_q       <= len_d;
         rep_q       <= rep_d;
         stop_pend_q <= stop_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         done_q      <= done_d;
         load_err_q  <= load_err_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign m_axis.data  = data_q;
   assign m_axis.valid = valid_q;
   assign m_axis.last  = last_q;
   assign busy_o       = (state_q == StStream);
   assign done_o       = done_q;
   assign load_err_o   = load_err_q;
   assign pkt_cnt_o    = pkt_cnt_q;

endmodule

// File: tb/tb_axis_msg_streamer.sv
// Randomized bench for axis_msg_streamer: a negedge monitor captures beats, and each
// scenario compares them against packets built from a behavioural buffer model.
module tb_axis_msg_streamer;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [W-1:0]  load_data;
   logic [AW:0]   msg_len;
   logic          repeat_mode;
   logic          start;
   logic          stop;
   logic          busy;
   logic          done;
   logic          load_err;
   logic [15:0]   pkt_cnt;

   axis_msg_streamer_if #(.WIDTH(W)) m_axis ();

   axis_msg_streamer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_en_i    (load_en),
      .load_addr_i  (load_addr),
      .load_data_i  (load_data),
      .msg_len_i    (msg_len),
      .repeat_mode_i(repeat_mode),
      .start_i      (start),
      .stop_i       (stop),
      .m_axis       (m_axis),
      .busy_o       (busy),
      .done_o       (done),
      .load_err_o   (load_err),
      .pkt_cnt_o    (pkt_cnt)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   int           ready_mode = 0;
   int           cyc = 0;
   int           hs_n, done_n, vc_n, last_hs_cyc, done_cyc;
   int           exp_pkts;
   logic [W:0]   got_q[$];
   logic [W:0]   exp_q[$];
   logic [W-1:0] mbuf[D];
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic         prev_last;

   always @(posedge clk) cyc++;

   initial begin
      int ph = 0;
      m_axis.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_axis.ready = 1'b1;
            1:       begin m_axis.ready = (ph % 3 == 0); ph++; end
            default: m_axis.ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Beat capture plus AXI-Stream hold-stability check.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (m_axis.valid !== 1'b1 || m_axis.data !== prev_data || m_axis.last !== prev_last) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b", m_axis.valid,
                        m_axis.data, m_axis.last, prev_data, prev_last);
            end
         end
         if (m_axis.valid === 1'b1) vc_n++;
         if (m_axis.valid === 1'b1 && m_axis.ready === 1'b1) begin
            got_q.push_back({m_axis.last, m_axis.data});
            hs_n++;
            last_hs_cyc = cyc;
         end
         if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
         end
         prev_stall = (m_axis.valid === 1'b1) && (m_axis.ready !== 1'b1);
         prev_data  = m_axis.data;
         prev_last  = m_axis.last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      hs_n   = 0;
      done_n = 0;
      vc_n   = 0;
   endtask

   task automatic reset_dut();
      load_en = 0; load_addr = '0; load_data = '0; msg_len = '0;
      repeat_mode = 0; start = 0; stop = 0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < D; i++) mbuf[i] = '0;
      exp_pkts = 0;
   endtask

   task automatic load_word(input int addr, input logic [W-1:0] data);
      load_en = 1; load_addr = AW'(addr); load_data = data;
      step();
      load_en = 0;
      mbuf[addr] = data;
   endtask

   task automatic start_pkt(input int len, input bit rep);
      msg_len = (AW+1)'(len); repeat_mode = rep; start = 1;
      step();
      start = 0;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done_n > 0) begin
            timed_out = 1'b0;
            break;
         end
         step();
      end
   endtask

   function automatic void build_exp(input int len, input int npk);
      for (int p = 0; p < npk; p++)
         for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), mbuf[i]});
   endfunction

   task automatic test_reset();
      reset_dut();
      checks++;
      if ({m_axis.valid, m_axis.last, m_axis.data} !== '0) begin
         errors++;
         $display("FAIL reset_axis: got v=%b l=%b d=%h, want all 0", m_axis.valid, m_axis.last,
                  m_axis.data);
      end
      checks++;
      if ({busy, done, load_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got busy/done/err=%b, want 000", {busy, done, load_err});
      end
      checks++;
      if (pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_pkt_cnt: got %0d, want 0", pkt_cnt);
      end
   endtask

   task automatic test_helo();
      bit to;
      ready_mode = 0;
      load_word(0, 8'h48); load_word(1, 8'h45); load_word(2, 8'h4C); load_word(3, 8'h4F);
      clear_mon();
      start_pkt(4, 0);
      checks++;
      if (m_axis.valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL helo_latency: got valid=%b busy=%b, want 1 1", m_axis.valid, busy);
      end
      wait_done(50, to);
      checks++;
      if (to) begin errors++; $display("FAIL helo_timeout: got no done, want done"); end
      build_exp(4, 1);
      exp_pkts++;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL helo_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL helo_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (vc_n != 4) begin errors++; $display("FAIL helo_valid_cycles: got %0d, want 4", vc_n); end
      checks++;
      if (done_cyc - last_hs_cyc != 1 || done_n != 1) begin
         errors++;
         $display("FAIL helo_done: got delay %0d count %0d, want 1 1", done_cyc - last_hs_cyc, done_n);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL helo_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
      end
      checks++;
      if (pkt_cnt !== 16'(exp_pkts)) begin
         errors++;
         $display("FAIL helo_pkt_cnt: got %0d, want %0d", pkt_cnt, exp_pkts);
      end
   endtask

   task automatic test_ready_toggle();
      bit to;
      ready_mode = 1;
      clear_mon();
      start_pkt(4, 0);
      wait_done(100, to);
      checks++;
      if (to) begin errors++; $display("FAIL toggle_timeout: got no done, want done"); end
      build_exp(4, 1);
      exp_pkts++;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL toggle_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL toggle_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (pkt_cnt !== 16'(exp_pkts)) begin
         errors++;
         $display("FAIL toggle_pkt_cnt: got %0d, want %0d", pkt_cnt, exp_pkts);
      end
   endtask

   task automatic test_repeat_stop();
      bit to;
      ready_mode = 0;
      for (int i = 0; i < 3; i++) load_word(i, 8'($urandom));
      clear_mon();
      start_pkt(3, 1);
      for (int i = 0; i < 20 && hs_n < 4; i++) step();
      stop = 1;
      step();
      stop = 0;
      wait_done(100, to);
      checks++;
      if (to) begin errors++; $display("FAIL repeat_timeout: got no done, want done"); end
      build_exp(3, 2);
      exp_pkts += 2;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL repeat_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL repeat_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (vc_n != 6) begin errors++; $display("FAIL repeat_no_bubble: got %0d, want 6", vc_n); end
      checks++;
      if (pkt_cnt !== 16'(exp_pkts)) begin
         errors++;
         $display("FAIL repeat_pkt_cnt: got %0d, want %0d", pkt_cnt, exp_pkts);
      end
   endtask

   task automatic test_load_err();
      bit to;
      ready_mode = 1;
      clear_mon();
      start_pkt(4, 0);
      load_en = 1; load_addr = '0; load_data = 8'hFF;
      step();
      load_en = 0;
      checks++;
      if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_set: got %b, want 1", load_err); end
      wait_done(100, to);
      exp_pkts++;
      checks++;
      if (to || load_err !== 1'b1) begin
         errors++;
         $display("FAIL load_err_sticky: got err=%b timeout=%b, want 1 0", load_err, to);
      end
      ready_mode = 0;
      clear_mon();
      start_pkt(4, 0);
      checks++;
      if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_clear: got %b, want 0", load_err); end
      wait_done(50, to);
      build_exp(4, 1);
      exp_pkts++;
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL load_err_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL load_err_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_len_zero();
      ready_mode = 0;
      clear_mon();
      start_pkt(0, 0);
      checks++;
      if (m_axis.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL len0_done: got v=%b busy=%b done=%b, want 0 0 1", m_axis.valid, busy, done);
      end
      step();
      checks++;
      if (done !== 1'b0 || hs_n != 0 || pkt_cnt !== 16'(exp_pkts)) begin
         errors++;
         $display("FAIL len0_after: got done=%b beats=%0d cnt=%0d, want 0 0 %0d", done, hs_n,
                  pkt_cnt, exp_pkts);
      end
   endtask

   task automatic test_len_over();
      bit to;
      ready_mode = 2;
      for (int i = 0; i < D; i++) load_word(i, 8'($urandom));
      clear_mon();
      start_pkt(D + 1, 0);
      wait_done(500, to);
      build_exp(D, 1);
      exp_pkts++;
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL over_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL over_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      ready_mode = 0;
      load_word(0, 8'hA5);
      start_pkt(4, 0);
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (m_axis.valid !== 1'b0 || busy !== 1'b0 || m_axis.last !== 1'b0 || pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_async: got v=%b busy=%b l=%b cnt=%0d, want 0 0 0 0", m_axis.valid,
                  busy, m_axis.last, pkt_cnt);
      end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < D; i++) mbuf[i] = '0;
      exp_pkts = 0;
      clear_mon();
      start_pkt(4, 0);
      wait_done(50, to);
      build_exp(4, 1);
      exp_pkts++;
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rst_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rst_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit to;
      int len, eff, npk, jb, j;
      bit rep, hs_now;
      ready_mode = 2;
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < int'($urandom_range(1, 6)); k++)
            load_word(int'($urandom_range(0, D - 1)), 8'($urandom));
         len = int'($urandom_range(0, D + 2));
         rep = 1'($urandom_range(0, 1));
         eff = (len > D) ? D : len;
         clear_mon();
         start_pkt(len, rep);
         npk = (eff == 0) ? 0 : 1;
         if (eff != 0 && rep) begin
            for (int c = 0; c < int'($urandom_range(1, 3 * eff)); c++) step();
            jb = hs_n;
            stop = 1;
            #2;
            hs_now = (m_axis.valid === 1'b1) && (m_axis.ready === 1'b1);
            @(posedge clk);
            #1;
            stop = 0;
            j = jb + int'(hs_now);
            npk = (hs_now && (j % eff == 0)) ? j / eff : j / eff + 1;
         end
         wait_done(1000, to);
         build_exp(eff, npk);
         exp_pkts += npk;
         checks++;
         if (to || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d beats timeout=%b, want %0d", it, got_q.size(),
                     to, exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               checks++;
               if (got_q[i] !== exp_q[i]) begin
                  errors++;
                  $display("FAIL rand%0d_beat%0d: got %h, want %h", it, i, got_q[i], exp_q[i]);
               end
            end
         end
         checks++;
         if (pkt_cnt !== 16'(exp_pkts)) begin
            errors++;
            $display("FAIL rand%0d_pkt_cnt: got %0d, want %0d", it, pkt_cnt, exp_pkts);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_helo();
      test_ready_toggle();
      test_repeat_stop();
      test_load_err();
      test_len_zero();
      test_len_over();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
